// File: rtl/tbird_button_conditioner_if.sv
// Pushbutton bundle between the board pins and the tbird turn-signal FSM.
// The slave side is the conditioner; the master side owns the raw buttons.
`default_nettype none

interface tbird_button_conditioner_if;
  logic right_raw_n;
  logic left_raw_n;
  logic hazard_raw_n;
  logic right_button;
  logic left_button;
  logic hazard_button;
  logic right_press;
  logic left_press;
  logic hazard_press;
  logic turn_conflict;

  modport master (
    output right_raw_n, left_raw_n, hazard_raw_n,
    input  right_button, left_button, hazard_button,
    input  right_press, left_press, hazard_press, turn_conflict
  );

  modport slave (
    input  right_raw_n, left_raw_n, hazard_raw_n,
    output right_button, left_button, hazard_button,
    output right_press, left_press, hazard_press, turn_conflict
  );
endinterface

`default_nettype wire

// File: rtl/tbird_button_conditioner.sv
// Synchronises, debounces and arbitrates the RIGHT/LEFT/HAZARD pushbuttons
// into clean active-low levels and one-cycle press pulses for the tbird FSM.
`default_nettype none

module tbird_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  wire logic clock,
  input  wire logic reset,
  tbird_button_conditioner_if.slave btn
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED      = 2'd0,
    CHECK_PRESS   = 2'd1,
    PRESSED       = 2'd2,
    CHECK_RELEASE = 2'd3
  } db_state_e;

  // Bit order throughout: 0 = RIGHT, 1 = LEFT, 2 = HAZARD.
  logic [2:0] raw_n;
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] level;
  logic [2:0] rise;
  logic       conflict;

  assign raw_n = {btn.hazard_raw_n, btn.left_raw_n, btn.right_raw_n};

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
    end else begin
      sync1_q <= raw_n;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_btn
    db_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             rise_q;
    logic             pressed;

    assign pressed  = ~sync2_q[i];
    assign level[i] = level_q;
    assign rise[i]  = rise_q;

    // level_q tracks (state == PRESSED || state == CHECK_RELEASE), updated on
    // the transitions that change it so it switches on the same edge as state.
    always_ff @(posedge clock) begin
      if (reset) begin
        state_q <= RELEASED;
        cnt_q   <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        case (state_q)
          RELEASED: begin
            if (pressed) begin
              state_q <= CHECK_PRESS;
              cnt_q   <= '0;
            end
          end
          CHECK_PRESS: begin
            if (!pressed) begin
              state_q <= RELEASED;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= PRESSED;
              level_q <= 1'b1;
              rise_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          PRESSED: begin
            if (!pressed) begin
              state_q <= CHECK_RELEASE;
              cnt_q   <= '0;
            end
          end
          CHECK_RELEASE: begin
            if (pressed) begin
              state_q <= PRESSED;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= RELEASED;
              level_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Both turn levels read released while LEFT and RIGHT are held together.
  assign conflict          = level[0] & level[1];
  assign btn.turn_conflict = conflict;
  assign btn.right_button  = ~(level[0] & ~level[1]);
  assign btn.left_button   = ~(level[1] & ~level[0]);
  assign btn.hazard_button = ~level[2];
  assign btn.right_press   = rise[0] & ~conflict;
  assign btn.left_press    = rise[1] & ~conflict;
  assign btn.hazard_press  = rise[2];

endmodule

`default_nettype wire

// File: tb/tb_tbird_button_conditioner.sv
// Directed and randomized checks of the button conditioner against a
// run-length debounce model.
`default_nettype none

module tb_tbird_button_conditioner;

  localparam int N = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  tbird_button_conditioner_if ifc ();

  tbird_button_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
    .clock (clock),
    .reset (reset),
    .btn   (ifc)
  );

  always #5 clock = ~clock;

  // Model: a button's debounced level flips once N+1 consecutive synchronised
  // samples disagree with it; the synchroniser is a plain two-cycle delay.
  logic [2:0] m_s1, m_s2, m_lvl, m_rise;
  int         m_run [3];

  task automatic check_eq(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [2:0] raw;
    raw = {ifc.hazard_raw_n, ifc.left_raw_n, ifc.right_raw_n};
    if (reset) begin
      m_s1 = 3'b111; m_s2 = 3'b111; m_lvl = '0; m_rise = '0;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_rise[i] = 1'b0;
        if (~m_s2[i] == m_lvl[i]) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] == N + 1) begin
            m_lvl[i]  = ~m_s2[i];
            m_rise[i] = ~m_s2[i];
            m_run[i]  = 0;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
  endtask

  task automatic check_outputs();
    logic cf;
    cf = m_lvl[0] & m_lvl[1];
    check_eq("turn_conflict", ifc.turn_conflict, cf);
    check_eq("right_button",  ifc.right_button,  ~(m_lvl[0] & ~m_lvl[1]));
    check_eq("left_button",   ifc.left_button,   ~(m_lvl[1] & ~m_lvl[0]));
    check_eq("hazard_button", ifc.hazard_button, ~m_lvl[2]);
    check_eq("right_press",   ifc.right_press,   m_rise[0] & ~cf);
    check_eq("left_press",    ifc.left_press,    m_rise[1] & ~cf);
    check_eq("hazard_press",  ifc.hazard_press,  m_rise[2]);
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Counts edges until right_button reads `target`, bounded.
  task automatic measure_right(input logic target, input string tag);
    int n;
    n = 0;
    while (ifc.right_button !== target && n < 20) begin
      tick();
      n++;
    end
    check_eq(tag, (n == N + 3), 1'b1);
  endtask

  initial begin
    ifc.right_raw_n  = 1'b1;
    ifc.left_raw_n   = 1'b1;
    ifc.hazard_raw_n = 1'b1;
    reset = 1'b1;
    ticks(3);
    check_eq("reset_right",  ifc.right_button,  1'b1);
    check_eq("reset_left",   ifc.left_button,   1'b1);
    check_eq("reset_hazard", ifc.hazard_button, 1'b1);
    check_eq("reset_cflt",   ifc.turn_conflict, 1'b0);
    reset = 1'b0;
    ticks(2);

    // Single RIGHT press and release
    ifc.right_raw_n = 1'b0;
    measure_right(1'b0, "right_press_latency");
    ticks(3);
    ifc.right_raw_n = 1'b1;
    measure_right(1'b1, "right_release_latency");
    ticks(3);

    // Short LEFT glitch never reaches the outputs
    ifc.left_raw_n = 1'b0;
    ticks(3);
    ifc.left_raw_n = 1'b1;
    ticks(10);
    check_eq("glitch_left", ifc.left_button, 1'b1);

    // RIGHT then LEFT: conflict, then LEFT release restores RIGHT
    ifc.right_raw_n = 1'b0;
    ticks(10);
    ifc.left_raw_n = 1'b0;
    ticks(10);
    check_eq("conflict_set", ifc.turn_conflict, 1'b1);
    ifc.hazard_raw_n = 1'b0;
    ticks(10);
    check_eq("hazard_during", ifc.hazard_button, 1'b0);
    ifc.left_raw_n = 1'b1;
    ticks(10);
    check_eq("right_restored", ifc.right_button, 1'b0);
    ifc.hazard_raw_n = 1'b1;
    ifc.right_raw_n  = 1'b1;
    ticks(10);

    // Reset mid-debounce with RIGHT held
    ifc.right_raw_n = 1'b0;
    ticks(5);
    reset = 1'b1;
    ticks(2);
    check_eq("reset_mid_right", ifc.right_button, 1'b1);
    reset = 1'b0;
    measure_right(1'b0, "post_reset_latency");
    ifc.right_raw_n = 1'b1;
    ticks(10);

    // Randomized segments with occasional resets
    for (int seg = 0; seg < 400; seg++) begin
      ifc.right_raw_n  = ($urandom_range(0, 2) != 0);
      ifc.left_raw_n   = ($urandom_range(0, 2) != 0);
      ifc.hazard_raw_n = ($urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 39) == 0);
      ticks($urandom_range(1, 10));
      reset = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
